// File: rtl/oven_pkg.sv
// Shared oven front-panel definitions: keypad FSM states, key codes, column
// reset pattern and small helpers for active-low one-hot vectors.
package oven_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // True when exactly one bit of an active-low vector is asserted.
    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    // Index of the asserted bit of an active-low one-hot vector.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] v);
        rotl4 = {v[2:0], v[3]};
    endfunction

    // Matrix position to the digit code shared with the segment decoder.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = KEY_A;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = KEY_B;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = KEY_C;
            4'hC: key_code = KEY_STAR;
            4'hD: key_code = 4'h0;
            4'hE: key_code = KEY_HASH;
            default: key_code = KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks, asserted while
// the internal counter sits at SCAN_DIV-1.
module tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(SCAN_DIV - 2);

    logic [CW-1:0] cnt;

    // tick is registered one count early so it lines up with cnt == SCAN_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/keypad_enc.sv
// 4x4 keypad scanner/debouncer/encoder. Define KEYPAD_REPEAT_EN to add
// auto-repeat strobes while a key stays held.
module keypad_enc
    import oven_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEB_TICKS    = 4,
    parameter int unsigned REPEAT_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS - 1);

    if (SCAN_DIV < 2 || DEB_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_enc: illegal parameter value");
    end

    logic            tick;
    logic [3:0]      row_meta, row_sync;
    kp_state_e       state_q, state_d;
    logic [3:0]      col_d, pat_q, pat_d, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            key_valid_d, key_held_d;
    logic [3:0]      code_c;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(2 * REPEAT_TICKS) + 1;
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(2 * REPEAT_TICKS - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_TICKS);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign code_c = key_code(low_index(row_sync), low_index(col));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        digit_d     = digit;
        key_valid_d = 1'b0;
        key_held_d  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (one_low(row_sync)) begin
                        pat_d = row_sync;
                        if (DEB_TICKS == 1) begin
                            state_d     = HELD;
                            cnt_d       = '0;
                            digit_d     = code_c;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        col_d = rotl4(col);
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (row_sync == pat_q) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d     = HELD;
                            cnt_d       = '0;
                            digit_d     = code_c;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = rotl4(col);
                        cnt_d   = '0;
                    end
                end
            end
            HELD: begin
                if (tick) begin
                    if (row_sync == 4'hF) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_d = '0;
`endif
                        if (cnt_q == DEB_LAST) begin
                            state_d    = SCAN;
                            col_d      = rotl4(col);
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_q == REP_FIRST) begin
                            rep_d       = REP_RELOAD;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
`endif
                    end
                end
            end
            default: begin
                state_d    = SCAN;
                col_d      = COL_RESET;
                cnt_d      = '0;
                key_held_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            state_q   <= SCAN;
            col       <= COL_RESET;
            pat_q     <= 4'hF;
            cnt_q     <= '0;
            digit     <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            state_q   <= state_d;
            col       <= col_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            digit     <= digit_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_enc.sv
// Bench for keypad_enc: a physical keypad model drives the rows from the
// column strobes; strobes are collected and compared against the key map.
module tb_keypad_enc;

    localparam int unsigned SD = 4;
    localparam int unsigned DT = 2;
    localparam int unsigned RT = 3;
    localparam longint LAT_MAX = 2 + 4 * SD + DT * SD + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] digit;
    logic       key_valid;
    logic       key_held;

    // keypad model and direct-row override
    logic       kp_on  = 1'b0;
    int         kp_r   = 0;
    int         kp_c   = 0;
    logic       ovr_on = 1'b0;
    logic [3:0] ovr_row = 4'hF;

    int     errors = 0;
    int     checks = 0;
    int     col_err_shown = 0;
    longint cyc = 0;
    logic [3:0] sdig[$];
    longint     scyc[$];

    logic [3:0] kmap [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_enc #(.SCAN_DIV(SD), .DEB_TICKS(DT), .REPEAT_TICKS(RT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .digit     (digit),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #20 clk = ~clk;

    always_comb begin
        if (ovr_on)
            row = ovr_row;
        else if (kp_on && col[kp_c] == 1'b0)
            row = ~(4'b0001 << kp_r);
        else
            row = 4'hF;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // strobe collector and column-drive invariant
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (key_valid === 1'b1) begin
                sdig.push_back(digit);
                scyc.push_back(cyc);
            end
            checks++;
            if ($countones(~col) != 1) begin
                errors++;
                if (col_err_shown < 5) begin
                    col_err_shown++;
                    $display("FAIL col_one_low: col=%b at cycle %0d, required exactly one low bit", col, cyc);
                end
            end
        end
    end

    function automatic logic [3:0] rot(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    task automatic ticks(input int n);
        repeat (n * SD) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_n = 1'b0;
        kp_on = 1'b0;
        ovr_on = 1'b0;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col); end
        checks++;
        if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h want 0", digit); end
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++; $display("FAIL reset_flags: valid=%b held=%b want 0 0", key_valid, key_held);
        end
        exp = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            exp = rot(exp);
            repeat (SD) @(posedge clk);
            #1;
            checks++;
            if (col !== exp) begin errors++; $display("FAIL scan_rotate%0d: got %b want %b", k, col, exp); end
        end
    endtask

    task automatic do_press(input int r, input int c, input int hold, input int gap, input string nm);
        int     n0;
        longint t0;
        logic [3:0] exp;
        exp = kmap[r * 4 + c];
        n0 = sdig.size();
        t0 = cyc;
        kp_r = r;
        kp_c = c;
        kp_on = 1'b1;
        ticks(hold);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL %s_held: got %b want 1", nm, key_held); end
        kp_on = 1'b0;
        ticks(1);
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL %s_held_after_release: got %b want 1", nm, key_held); end
        ticks(gap);
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL %s_released: got %b want 0", nm, key_held); end
        checks++;
`ifdef KEYPAD_REPEAT_EN
        if (sdig.size() - n0 < 1) begin
`else
        if (sdig.size() - n0 != 1) begin
`endif
            errors++; $display("FAIL %s_strobes: got %0d want 1", nm, sdig.size() - n0);
        end
        if (sdig.size() > n0) begin
            for (int i = n0; i < sdig.size(); i++) begin
                checks++;
                if (sdig[i] !== exp) begin errors++; $display("FAIL %s_digit: got %h want %h", nm, sdig[i], exp); end
            end
            checks++;
            if (scyc[n0] - t0 > LAT_MAX) begin
                errors++; $display("FAIL %s_latency: got %0d cycles want <= %0d", nm, scyc[n0] - t0, LAT_MAX);
            end
        end
        checks++;
        if (digit !== exp) begin errors++; $display("FAIL %s_digit_hold: got %h want %h", nm, digit, exp); end
    endtask

    task automatic test_key9();
        logic [3:0] prev;
        do_press(2, 2, 20, 6, "key9");
        prev = col;
        ticks(1);
        checks++;
        if (col !== rot(prev)) begin errors++; $display("FAIL key9_rescan: got %b want %b", col, rot(prev)); end
    endtask

    task automatic test_back_to_back();
        do_press(3, 2, 10, 5, "hash");
        do_press(3, 1, 10, 5, "zero");
    endtask

    task automatic test_bounce();
        int n0;
        int guard;
        n0 = sdig.size();
        kp_r = 0;
        kp_c = 0;
        guard = 0;
        while (col !== 4'b1110 && guard < 8 * SD) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (col !== 4'b1110) begin errors++; $display("FAIL bounce_col_wait: got %b want 1110", col); end
        kp_on = 1'b1;
        ticks(1);
        kp_on = 1'b0;
        ticks(1);
        checks++;
        if (sdig.size() != n0) begin errors++; $display("FAIL bounce_no_strobe: got %0d want 0", sdig.size() - n0); end
        do_press(0, 0, 10, 5, "bounce_key1");
    endtask

    task automatic test_ghost();
        int n0;
        logic [3:0] prev;
        n0 = sdig.size();
        ovr_row = 4'b1100;
        ovr_on = 1'b1;
        prev = col;
        for (int k = 0; k < 8; k++) begin
            ticks(1);
            checks++;
            if (col !== rot(prev)) begin errors++; $display("FAIL ghost_rotate%0d: got %b want %b", k, col, rot(prev)); end
            prev = rot(prev);
        end
        ovr_on = 1'b0;
        checks++;
        if (sdig.size() != n0) begin errors++; $display("FAIL ghost_no_strobe: got %0d want 0", sdig.size() - n0); end
    endtask

    task automatic test_midreset();
        int n1;
        int guard;
        kp_r = 1;
        kp_c = 2;
        kp_on = 1'b1;
        guard = 0;
        while (key_held !== 1'b1 && guard < 2 * LAT_MAX) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (key_held !== 1'b1) begin errors++; $display("FAIL midreset_enter_held: got %b want 1", key_held); end
        ticks(1);
        n1 = sdig.size();
        @(negedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (key_held !== 1'b0 || col !== 4'b1110 || key_valid !== 1'b0 || digit !== 4'h0) begin
            errors++;
            $display("FAIL midreset_async: held=%b col=%b valid=%b digit=%h want 0 1110 0 0", key_held, col, key_valid, digit);
        end
        kp_on = 1'b0;
        #60;
        rst_n = 1'b1;
        ticks(10);
        checks++;
        if (sdig.size() != n1 || key_held !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet: strobes=%0d held=%b want 0 0", sdig.size() - n1, key_held);
        end
    endtask

    task automatic test_random();
        int r, c, h;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            h = $urandom_range(8, 20);
            do_press(r, c, h, 5, "random");
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int     n0;
        int     guard;
        longint te;
        longint offs [0:4];
        offs = '{0, 2 * RT * SD, 3 * RT * SD, 4 * RT * SD, 5 * RT * SD};
        n0 = sdig.size();
        kp_r = 1;
        kp_c = 1;
        kp_on = 1'b1;
        guard = 0;
        while (sdig.size() == n0 && guard < 2 * LAT_MAX) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (sdig.size() == n0) begin
            errors++; $display("FAIL repeat_accept: got 0 strobes want 1");
            kp_on = 1'b0;
            ticks(6);
        end else begin
            te = scyc[n0];
            while (cyc < te + 5 * RT * SD + 1) begin
                @(posedge clk);
                #1;
            end
            kp_on = 1'b0;
            ticks(6);
            checks++;
            if (sdig.size() - n0 != 5) begin errors++; $display("FAIL repeat_count: got %0d want 5", sdig.size() - n0); end
            for (int i = 0; i < 5 && n0 + i < sdig.size(); i++) begin
                checks++;
                if (scyc[n0 + i] - te != offs[i] || sdig[n0 + i] !== 4'h5) begin
                    errors++;
                    $display("FAIL repeat_strobe%0d: offset=%0d digit=%h want %0d 5", i, scyc[n0 + i] - te, sdig[n0 + i], offs[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_key9();
        test_back_to_back();
        test_bounce();
        test_ghost();
        test_midreset();
        test_random();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
